// File: rtl/inst_prefetch_ctrl.sv
// Instruction prefetch controller: owns the fetch PC, drives the ROM address and
// buffers fetched words in an in-order queue drained by decode via valid/ready.
module inst_prefetch_ctrl #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [9:0]             rom_addr,
  input  logic [31:0]            rom_dout,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   halt,
  output logic                   inst_valid,
  output logic [31:0]            inst,
  output logic [31:0]            inst_pc,
  input  logic                   inst_ready,
  output logic [$clog2(DEPTH):0] q_count,
  output logic [15:0]            redirect_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_word [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          deq;
  logic          push;
  logic          unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  assign inst_valid = (count != '0);
  assign deq        = inst_valid & inst_ready & ~redirect_valid;
  // A full queue may still accept a word when the head leaves in the same cycle.
  assign push       = ~redirect_valid & ~halt & ~rst & ((count < FULL) | deq);

  assign rom_addr = fetch_pc[11:2];
  assign q_count  = count;
  assign inst     = inst_valid ? q_word[rd_ptr] : '0;
  assign inst_pc  = inst_valid ? q_pc[rd_ptr]   : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      redirect_cnt <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      if (redirect_cnt != '1)
        redirect_cnt <= redirect_cnt + 16'd1;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (deq)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= fetch_pc;
      q_word[wr_ptr] <= rom_dout;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_ctrl.sv
// Bench for inst_prefetch_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_inst_prefetch_ctrl;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rom_addr;
  logic [31:0] rom_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [2:0]  q_count;
  logic [15:0] redirect_cnt;

  logic [31:0] rom [1024];

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;
  logic [15:0] mred;
  bit          mstarted = 0;

  always #5 clk = ~clk;

  assign rom_dout = rom[rom_addr];

  inst_prefetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .q_count(q_count), .redirect_cnt(redirect_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: update at each rising edge, compare at the following falling edge.
  initial begin
    bit do_deq;
    bit do_push;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        mpc  = RPC;
        mred = '0;
      end else if (redirect_valid) begin
        mq.delete();
        mpc = {redirect_pc[31:2], 2'b00};
        if (mred != 16'hFFFF) mred = mred + 16'd1;
      end else begin
        do_deq  = inst_ready && (mq.size() > 0);
        do_push = !halt && ((mq.size() < DEPTH) || do_deq);
        if (do_deq) void'(mq.pop_front());
        if (do_push) begin
          mq.push_back('{pc: mpc, w: rom[mpc[11:2]]});
          mpc = mpc + 32'd4;
        end
      end
      mstarted = 1;
      @(negedge clk);
      chk("rom_addr", 32'(rom_addr), 32'(mpc[11:2]));
      chk("inst_valid", 32'(inst_valid), (mq.size() != 0) ? 32'd1 : 32'd0);
      chk("inst", inst, (mq.size() != 0) ? mq[0].w : 32'd0);
      chk("inst_pc", inst_pc, (mq.size() != 0) ? mq[0].pc : 32'd0);
      chk("q_count", 32'(q_count), 32'(mq.size()));
      chk("redirect_cnt", 32'(redirect_cnt), 32'(mred));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] held;
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[0]     = 32'h00100493;
    rom[1]     = 32'h0100006f;
    rom[10'h11] = 32'h3a0000ef;

    rst = 1; redirect_valid = 0; redirect_pc = '0; halt = 0; inst_ready = 1;
    tick(); tick();
    look();
    chk("reset_valid", 32'(inst_valid), 32'd0);
    chk("reset_inst", inst, 32'd0);
    chk("reset_pc", inst_pc, 32'd0);
    chk("reset_count", 32'(q_count), 32'd0);
    chk("reset_romaddr", 32'(rom_addr), 32'd0);
    chk("reset_redcnt", 32'(redirect_cnt), 32'd0);

    // free run from reset
    rst = 0;
    tick(); look();
    chk("first_valid", 32'(inst_valid), 32'd1);
    chk("first_inst", inst, 32'h00100493);
    chk("first_pc", inst_pc, 32'd0);
    tick(); look();
    chk("second_inst", inst, 32'h0100006f);
    chk("second_pc", inst_pc, 32'd4);

    // backpressure
    rst = 1; tick();
    rst = 0; inst_ready = 0;
    for (int i = 0; i < 10; i++) tick();
    look();
    chk("bp_count", 32'(q_count), 32'd4);
    chk("bp_romaddr", 32'(rom_addr), 32'd4);
    chk("bp_headpc", inst_pc, 32'd0);
    inst_ready = 1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_drain_pc", inst_pc, 32'(i * 4));
      chk("bp_drain_valid", 32'(inst_valid), 32'd1);
      tick(); look();
    end

    // redirect with three entries queued
    rst = 1; tick();
    rst = 0; inst_ready = 0;
    tick(); tick(); tick(); look();
    chk("rd_pre_count", 32'(q_count), 32'd3);
    redirect_valid = 1; redirect_pc = 32'h46; inst_ready = 1;
    tick(); redirect_valid = 0; look();
    chk("rd_count", 32'(q_count), 32'd0);
    chk("rd_valid", 32'(inst_valid), 32'd0);
    chk("rd_romaddr", 32'(rom_addr), 32'h11);
    tick(); look();
    chk("rd_inst", inst, 32'h3a0000ef);
    chk("rd_pc", inst_pc, 32'h44);
    chk("rd_cnt", 32'(redirect_cnt), 32'd1);

    // halt drains the queue and freezes fetch
    halt = 1;
    held = rom_addr;
    for (int i = 0; i < 5; i++) begin
      tick(); look();
      chk("halt_romaddr", 32'(rom_addr), 32'(held));
    end
    chk("halt_count", 32'(q_count), 32'd0);
    chk("halt_valid", 32'(inst_valid), 32'd0);
    halt = 0;
    tick(); look();
    chk("resume_valid", 32'(inst_valid), 32'd1);
    chk("resume_pc", inst_pc, 32'h48);

    // ROM address aliasing across 0x1000
    redirect_valid = 1; redirect_pc = 32'hFFC;
    tick(); redirect_valid = 0; look();
    chk("wrap_romaddr0", 32'(rom_addr), 32'h3FF);
    tick(); look();
    chk("wrap_pc0", inst_pc, 32'hFFC);
    chk("wrap_romaddr1", 32'(rom_addr), 32'h000);
    tick(); look();
    chk("wrap_pc1", inst_pc, 32'h1000);
    chk("wrap_inst1", inst, 32'h00100493);
    chk("wrap_cnt", 32'(redirect_cnt), 32'd2);

    // reset while full, together with redirect and halt
    inst_ready = 0;
    for (int i = 0; i < 6; i++) tick();
    look();
    chk("prerst_count", 32'(q_count), 32'd4);
    rst = 1; redirect_valid = 1; redirect_pc = 32'h200; halt = 1;
    tick(); look();
    chk("midrst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_inst", inst, 32'd0);
    chk("midrst_pc", inst_pc, 32'd0);
    chk("midrst_count", 32'(q_count), 32'd0);
    chk("midrst_romaddr", 32'(rom_addr), 32'd0);
    chk("midrst_redcnt", 32'(redirect_cnt), 32'd0);
    rst = 0; redirect_valid = 0; halt = 0; inst_ready = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 32'h1FFF));
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      inst_ready     = ($urandom_range(0, 3) != 0);
      tick();
    end
    look();
    chk("model_started", 32'(mstarted), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
